// File: rtl/tlul_ast_resp_stub_if.sv
// TL-UL bus bundle between a host and the AST responder stub.
// The host drives the A channel and d_ready; the device drives the D channel and a_ready.
interface tlul_ast_resp_stub_if;
   // A channel (host -> device)
   logic        a_valid;
   logic [2:0]  a_opcode;
   logic [1:0]  a_size;
   logic [7:0]  a_source;
   logic [31:0] a_address;
   logic [3:0]  a_mask;
   logic [31:0] a_data;
   logic        d_ready;

   // D channel (device -> host)
   logic        d_valid;
   logic [2:0]  d_opcode;
   logic [2:0]  d_param;
   logic [1:0]  d_size;
   logic [7:0]  d_source;
   logic        d_sink;
   logic [31:0] d_data;
   logic [6:0]  d_user;
   logic        d_error;
   logic        a_ready;

   modport master (
      output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
      input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_user, d_error,
             a_ready
   );

   modport slave (
      input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
      output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_user, d_error,
             a_ready
   );
endinterface

// File: rtl/tlul_ast_resp_stub.sv
// TL-UL device-side responder standing in for the AST register block.
// Small register file, one transaction at a time, programmable response latency.
// The register access happens at A acceptance; the response is held until d_ready.
module tlul_ast_resp_stub #(
   parameter int unsigned NumRegs     = 8,
   parameter logic [31:0] BaseAddr    = 32'h4048_0000,
   parameter int unsigned RspLatency  = 1,
   parameter logic [31:0] RegResetVal = 32'h0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   tlul_ast_resp_stub_if.slave    tl,
   output logic [NumRegs*32-1:0]  regs_o,
   output logic                   busy_o
);

   localparam int unsigned IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;
   localparam int unsigned CntW = 4;

   localparam logic [2:0] OpPutFull    = 3'd0;
   localparam logic [2:0] OpPutPartial = 3'd1;
   localparam logic [2:0] OpGet        = 3'd4;

   localparam logic [2:0] OpAccessAck     = 3'd0;
   localparam logic [2:0] OpAccessAckData = 3'd1;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } state_e;

   state_e              state_q;
   logic [CntW-1:0]     cnt_q;
   logic [NumRegs*32-1:0] regs_q;

   logic                a_ready_q;
   logic                d_valid_q;
   logic [2:0]          d_opcode_q;
   logic [1:0]          d_size_q;
   logic [7:0]          d_source_q;
   logic [31:0]         d_data_q;
   logic                d_error_q;
   logic                busy_q;

   logic [29:0]         word_off;
   logic                in_range;
   logic [IdxW-1:0]     idx;
   logic                is_get;
   logic                is_put_full;
   logic                is_put_part;
   logic                req_err;
   logic                accept;
   logic                wr_en;
   logic [31:0]         rd_data;

   // Address decode: word offset from the base; byte offset bits are ignored.
   assign word_off    = tl.a_address[31:2] - BaseAddr[31:2];
   assign in_range    = (tl.a_address >= BaseAddr) && (word_off < 30'(NumRegs));
   assign idx         = word_off[IdxW-1:0];

   assign is_get      = (tl.a_opcode == OpGet);
   assign is_put_full = (tl.a_opcode == OpPutFull);
   assign is_put_part = (tl.a_opcode == OpPutPartial);

   assign req_err = !in_range
                 || (tl.a_size != 2'd2)
                 || !(is_get || is_put_full || is_put_part)
                 || (is_put_full && (tl.a_mask != 4'hF));

   assign accept  = (state_q == StIdle) && tl.a_valid;
   assign wr_en   = accept && !req_err && (is_put_full || is_put_part);
   assign rd_data = in_range ? regs_q[32*int'(idx) +: 32] : 32'hFFFF_FFFF;

   // Register file: byte-lane writes land on the acceptance edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         regs_q <= {NumRegs{RegResetVal}};
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (tl.a_mask[b]) begin
               regs_q[32*int'(idx) + 8*b +: 8] <= tl.a_data[8*b +: 8];
            end
         end
      end
   end

   // Transaction FSM with registered handshake and D-channel outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         a_ready_q  <= 1'b1;
         d_valid_q  <= 1'b0;
         d_opcode_q <= '0;
         d_size_q   <= '0;
         d_source_q <= '0;
         d_data_q   <= '0;
         d_error_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  state_q    <= StWait;
                  cnt_q      <= CntW'(RspLatency - 1);
                  a_ready_q  <= 1'b0;
                  busy_q     <= 1'b1;
                  d_opcode_q <= is_get ? OpAccessAckData : OpAccessAck;
                  d_size_q   <= tl.a_size;
                  d_source_q <= tl.a_source;
                  d_error_q  <= req_err;
                  // Read data is frozen here so later writes cannot alter the response.
                  d_data_q   <= is_get ? (req_err ? 32'hFFFF_FFFF : rd_data) : 32'h0;
               end
            end
            StWait: begin
               if (cnt_q == '0) begin
                  state_q   <= StResp;
                  d_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StResp: begin
               if (tl.d_ready) begin
                  state_q   <= StIdle;
                  d_valid_q <= 1'b0;
                  a_ready_q <= 1'b1;
                  busy_q    <= 1'b0;
               end
            end
            default: begin
               state_q   <= StIdle;
               d_valid_q <= 1'b0;
               a_ready_q <= 1'b1;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign tl.a_ready  = a_ready_q;
   assign tl.d_valid  = d_valid_q;
   assign tl.d_opcode = d_opcode_q;
   assign tl.d_param  = 3'd0;
   assign tl.d_size   = d_size_q;
   assign tl.d_source = d_source_q;
   assign tl.d_sink   = 1'b0;
   assign tl.d_data   = d_data_q;
   assign tl.d_user   = 7'd0;
   assign tl.d_error  = d_error_q;

   assign regs_o = regs_q;
   assign busy_o = busy_q;

endmodule

// File: tb/tb_tlul_ast_resp_stub.sv
// Directed bench for the TL-UL AST responder stub: a vector table of single
// transactions plus hand-written throughput, stall and mid-WAIT reset sequences.
module tb_tlul_ast_resp_stub;

   localparam int unsigned NREGS = 8;
   localparam logic [31:0] BASE  = 32'h4048_0000;
   localparam int unsigned LAT   = 3;
   localparam logic [31:0] RVAL  = 32'h0;

   logic clk;
   logic rst;
   logic [NREGS*32-1:0] regs;
   logic busy;

   tlul_ast_resp_stub_if tl_bus ();

   tlul_ast_resp_stub #(
      .NumRegs     (NREGS),
      .BaseAddr    (BASE),
      .RspLatency  (LAT),
      .RegResetVal (RVAL)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .tl     (tl_bus),
      .regs_o (regs),
      .busy_o (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] src_cnt = 8'h10;

   typedef struct {
      string       nm;
      logic [2:0]  opc;
      logic [1:0]  sz;
      logic [31:0] off;
      logic [3:0]  mask;
      logic [31:0] data;
      logic [2:0]  e_opc;
      logic        e_err;
      logic [31:0] e_data;
      int          ci;
      logic [31:0] e_reg;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] reg_at(input int k);
      return regs[32*k +: 32];
   endfunction

   // One complete transaction with d_ready asserted once the response is up.
   task automatic run_txn(input string nm, input logic [2:0] opc, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                          input logic [2:0] e_opc, input logic e_err, input logic [31:0] e_data,
                          input int ci, input logic [31:0] e_reg);
      int lat;
      logic [7:0] src;
      src = src_cnt;
      src_cnt++;
      @(negedge clk);
      chk($sformatf("%s.a_ready_idle", nm), 32'(tl_bus.a_ready), 32'd1);
      tl_bus.a_opcode  = opc;
      tl_bus.a_size    = sz;
      tl_bus.a_address = addr;
      tl_bus.a_mask    = mask;
      tl_bus.a_data    = data;
      tl_bus.a_source  = src;
      tl_bus.a_valid   = 1'b1;
      @(posedge clk);
      #1;
      tl_bus.a_valid = 1'b0;
      chk($sformatf("%s.busy", nm), 32'(busy), 32'd1);
      chk($sformatf("%s.a_ready_busy", nm), 32'(tl_bus.a_ready), 32'd0);
      chk($sformatf("%s.reg", nm), reg_at(ci), e_reg);
      lat = 1;
      while (!tl_bus.d_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk($sformatf("%s.latency", nm), 32'(lat), 32'(LAT + 1));
      chk($sformatf("%s.d_opcode", nm), 32'(tl_bus.d_opcode), 32'(e_opc));
      chk($sformatf("%s.d_error", nm), 32'(tl_bus.d_error), 32'(e_err));
      chk($sformatf("%s.d_data", nm), tl_bus.d_data, e_data);
      chk($sformatf("%s.d_size", nm), 32'(tl_bus.d_size), 32'(sz));
      chk($sformatf("%s.d_source", nm), 32'(tl_bus.d_source), 32'(src));
      chk($sformatf("%s.d_zero_fields", nm),
          {20'd0, tl_bus.d_param, tl_bus.d_sink, tl_bus.d_user, 1'b0}, 32'd0);
      @(negedge clk);
      tl_bus.d_ready = 1'b1;
      @(posedge clk);
      #1;
      tl_bus.d_ready = 1'b0;
      chk($sformatf("%s.d_valid_drop", nm), 32'(tl_bus.d_valid), 32'd0);
      chk($sformatf("%s.idle", nm), {30'd0, tl_bus.a_ready, busy}, 32'd2);
   endtask

   int acc_cyc[$];
   int wait_cnt;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{"get_r1",       3'd4, 2'd2, 32'd4,          4'hF, 32'h0,         3'd1, 1'b0, 32'h0,         1, 32'h0};
      vecs[1]  = '{"putfull_r2",   3'd0, 2'd2, 32'd8,          4'hF, 32'hDEAD_BEEF, 3'd0, 1'b0, 32'h0,         2, 32'hDEAD_BEEF};
      vecs[2]  = '{"get_r2",       3'd4, 2'd2, 32'd8,          4'hF, 32'h0,         3'd1, 1'b0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF};
      vecs[3]  = '{"putpart_r2",   3'd1, 2'd2, 32'd8,          4'h5, 32'h1122_3344, 3'd0, 1'b0, 32'h0,         2, 32'hDE22_BE44};
      vecs[4]  = '{"get_r2_part",  3'd4, 2'd2, 32'd8,          4'hF, 32'h0,         3'd1, 1'b0, 32'hDE22_BE44, 2, 32'hDE22_BE44};
      vecs[5]  = '{"get_oor_high", 3'd4, 2'd2, 32'd32,         4'hF, 32'h0,         3'd1, 1'b1, 32'hFFFF_FFFF, 2, 32'hDE22_BE44};
      vecs[6]  = '{"put_size1",    3'd0, 2'd1, 32'd8,          4'hF, 32'h0,         3'd0, 1'b1, 32'h0,         2, 32'hDE22_BE44};
      vecs[7]  = '{"get_oor_low",  3'd4, 2'd2, 32'hFFFF_FFFC,  4'hF, 32'h0,         3'd1, 1'b1, 32'hFFFF_FFFF, 0, 32'h0};
      vecs[8]  = '{"bad_opcode",   3'd2, 2'd2, 32'd8,          4'hF, 32'h0,         3'd0, 1'b1, 32'h0,         2, 32'hDE22_BE44};
      vecs[9]  = '{"putfull_mask", 3'd0, 2'd2, 32'd12,         4'h3, 32'h1234_5678, 3'd0, 1'b1, 32'h0,         3, 32'h0};
      vecs[10] = '{"put_r7_lowb",  3'd0, 2'd2, 32'd31,         4'hF, 32'hCAFE_F00D, 3'd0, 1'b0, 32'h0,         7, 32'hCAFE_F00D};
      vecs[11] = '{"get_r7",       3'd4, 2'd2, 32'd28,         4'hF, 32'h0,         3'd1, 1'b0, 32'hCAFE_F00D, 7, 32'hCAFE_F00D};
      vecs[12] = '{"get_size0",    3'd4, 2'd0, 32'd4,          4'hF, 32'h0,         3'd1, 1'b1, 32'hFFFF_FFFF, 1, 32'h0};

      tl_bus.a_valid   = 1'b0;
      tl_bus.a_opcode  = 3'd0;
      tl_bus.a_size    = 2'd0;
      tl_bus.a_source  = 8'd0;
      tl_bus.a_address = 32'd0;
      tl_bus.a_mask    = 4'd0;
      tl_bus.a_data    = 32'd0;
      tl_bus.d_ready   = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.a_ready", 32'(tl_bus.a_ready), 32'd1);
      chk("rst.d_valid", 32'(tl_bus.d_valid), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.d_fields", {tl_bus.d_data[31:16] | tl_bus.d_data[15:0], 3'd0, tl_bus.d_opcode,
          tl_bus.d_size, tl_bus.d_source, tl_bus.d_error}, 32'd0);
      for (int k = 0; k < NREGS; k++) chk($sformatf("rst.reg%0d", k), reg_at(k), RVAL);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         run_txn(vecs[i].nm, vecs[i].opc, vecs[i].sz, BASE + vecs[i].off, vecs[i].mask,
                 vecs[i].data, vecs[i].e_opc, vecs[i].e_err, vecs[i].e_data,
                 vecs[i].ci, vecs[i].e_reg);
      end

      // Back-to-back Gets with d_ready high: acceptances spaced LAT+2 cycles.
      @(negedge clk);
      tl_bus.a_opcode  = 3'd4;
      tl_bus.a_size    = 2'd2;
      tl_bus.a_address = BASE + 32'd4;
      tl_bus.a_mask    = 4'hF;
      tl_bus.d_ready   = 1'b1;
      tl_bus.a_valid   = 1'b1;
      for (int n = 0; n < 40 && acc_cyc.size() < 3; n++) begin
         if (n > 0) @(negedge clk);
         if (tl_bus.a_valid && tl_bus.a_ready) acc_cyc.push_back(n);
      end
      @(posedge clk);
      #1;
      tl_bus.a_valid = 1'b0;
      chk("thru.count", 32'(acc_cyc.size()), 32'd3);
      if (acc_cyc.size() == 3) begin
         chk("thru.gap0", 32'(acc_cyc[1] - acc_cyc[0]), 32'(LAT + 2));
         chk("thru.gap1", 32'(acc_cyc[2] - acc_cyc[1]), 32'(LAT + 2));
      end
      wait_cnt = 0;
      while (busy && wait_cnt < 40) begin
         @(posedge clk);
         #1;
         wait_cnt++;
      end
      tl_bus.d_ready = 1'b0;
      chk("thru.drain", 32'(busy), 32'd0);

      // Stall in RESP for 10 cycles while a write attempt is presented.
      @(negedge clk);
      tl_bus.a_opcode  = 3'd4;
      tl_bus.a_address = BASE + 32'd8;
      tl_bus.a_source  = 8'hA5;
      tl_bus.a_valid   = 1'b1;
      @(posedge clk);
      #1;
      tl_bus.a_valid = 1'b0;
      wait_cnt = 0;
      while (!tl_bus.d_valid && wait_cnt < 40) begin
         @(posedge clk);
         #1;
         wait_cnt++;
      end
      @(negedge clk);
      tl_bus.a_opcode  = 3'd0;
      tl_bus.a_data    = 32'h0;
      tl_bus.a_source  = 8'h5A;
      tl_bus.a_valid   = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("stall%0d.d_valid", c), 32'(tl_bus.d_valid), 32'd1);
         chk($sformatf("stall%0d.d_data", c), tl_bus.d_data, 32'hDE22_BE44);
         chk($sformatf("stall%0d.d_ctl", c),
             {16'd0, tl_bus.d_source, 1'b0, tl_bus.d_opcode, tl_bus.d_size, tl_bus.d_error, tl_bus.a_ready},
             {16'd0, 8'hA5, 1'b0, 3'd1, 2'd2, 1'b0, 1'b0});
         chk($sformatf("stall%0d.reg2", c), reg_at(2), 32'hDE22_BE44);
      end
      @(negedge clk);
      tl_bus.a_valid = 1'b0;
      tl_bus.d_ready = 1'b1;
      @(posedge clk);
      #1;
      tl_bus.d_ready = 1'b0;
      chk("stall.release", {30'd0, tl_bus.d_valid, tl_bus.a_ready}, 32'd1);

      // Load a register, then assert reset asynchronously while in WAIT.
      run_txn("put_r5", 3'd0, 2'd2, BASE + 32'd20, 4'hF, 32'h55AA_55AA,
              3'd0, 1'b0, 32'h0, 5, 32'h55AA_55AA);
      @(negedge clk);
      tl_bus.a_opcode  = 3'd4;
      tl_bus.a_address = BASE + 32'd20;
      tl_bus.a_valid   = 1'b1;
      @(posedge clk);
      #1;
      tl_bus.a_valid = 1'b0;
      @(posedge clk);
      #2;
      chk("rstwait.busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstwait.d_valid", 32'(tl_bus.d_valid), 32'd0);
      chk("rstwait.a_ready", 32'(tl_bus.a_ready), 32'd1);
      chk("rstwait.busy", 32'(busy), 32'd0);
      for (int k = 0; k < NREGS; k++) chk($sformatf("rstwait.reg%0d", k), reg_at(k), RVAL);
      @(negedge clk);
      rst = 1'b0;
      run_txn("get_r5_after_rst", 3'd4, 2'd2, BASE + 32'd20, 4'hF, 32'h0,
              3'd1, 1'b0, 32'h0, 5, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
